alu_bist_ctrl: RTL and testbench
================================

// Module: alu_bist_ctrl
// PURPOSE
//  Built-in self-test initiator for the redundant ALU. Drives pseudo-random operand/opcode vectors into the
//  ALU, compares result and zero against an internal golden model, and reports pass/fail with first-failure capture.
//  Sits beside the datapath. test_mode steers the ALU input muxes to this block.
// PARAMETERS
//  NUM_VECTORS  256           vectors per run; legal range 1..65535
//  SEED         32'hACE12345  LFSR load value at start; 0 is replaced by 32'h00000001
// PORTS
//  clk                  in   1   system clock, rising edge
//  reset                in   1   synchronous, active-high
//  start                in   1   begin run; sampled in IDLE or DONE only
//  abort                in   1   abandon run; any state -> IDLE
//  alu_result           in   32  ALU result, combinational response to alu_a/alu_b/alu_alucont
//  alu_zero             in   1   ALU zero flag
//  test_mode            out  1   high while busy; selects BIST operands into ALU
//  alu_a, alu_b         out  32  registered operands
//  alu_alucont          out  3   registered ALU control
//  busy                 out  1   state==RUN
//  done                 out  1   state==DONE
//  pass                 out  1   done && fail_count==0
//  fail_count           out  16  mismatching vectors, saturates at 16'hFFFF
//  first_fail_index     out  16  vector index of first mismatch
//  first_fail_result    out  32  alu_result captured at first mismatch
//  first_fail_expected  out  32  golden result at first mismatch
// BEHAVIOUR
//  Reset (clk edge with reset=1): state IDLE. All outputs 0. alu_alucont=3'b010. lfsr=SEED (0->1). idx=0, op_sel=0.
//  FSM: IDLE --start--> RUN; RUN --last compare--> DONE; DONE --start--> RUN; any --abort--> IDLE (reset > abort > start).
//  start while RUN is ignored. On entry to RUN: fail_count, first_fail_* cleared; idx=0, op_sel=0, lfsr=SEED.
//  Vector k (registered, visible the cycle after the edge that issued it):
//   alu_a = lfsr; alu_b = (k[2:0]==3'b110) ? lfsr : {lfsr[15:0],lfsr[31:16]}.
//   op_sel 0..4 -> alucont 010 add, 110 sub, 000 and, 001 or, 111 slt; op_sel wraps 4->0.
//  LFSR: 32-bit Galois, shift right, XOR 32'h80200003 when shifted-out bit is 1; advances once per vector.
//  Golden model on registered outputs: add a+b, sub a+~b+1 (mod 2^32), and a&b, or a|b,
//   slt = {31'b0, bit31 of (a+~b+1)} (no overflow correction); expected zero = (expected result==0).
//  Compare: every RUN edge checks alu_result/alu_zero against the vector currently driven. Either mismatch -> fail.
//   On first fail of the run, capture first_fail_index=idx, first_fail_result=alu_result, first_fail_expected=golden.
//  Latency: start edge E0 drives vector 0. Vector k is compared at E(k+1). After compare of NUM_VECTORS-1 at
//   E(NUM_VECTORS), state=DONE. busy is high exactly NUM_VECTORS cycles.
//  IDLE/DONE: operands hold last values; test_mode=0; no compares. Results hold in DONE and after abort until next start.
//  abort mid-run: IDLE next edge, done=0, partial counts retained, no further compares.
// TESTING
//  1 SEED=1, NUM_VECTORS=5, fault-free ALU, start pulse -> vec0 a=32'h00000001 b=32'h00010000 alucont=010;
//    busy 5 cycles; done=1, pass=1, fail_count=0.
//  2 SEED=1, result[0] stuck-at-0 -> fail_count>=1, first_fail_index=0, first_fail_result=32'h00010000,
//    first_fail_expected=32'h00010001, pass=0.
//  3 NUM_VECTORS=8, fault-free: vector 6 (sub, b==a) -> alu_zero=1 expected and matched; pass=1.
//  4 alu_zero stuck-at-1, NUM_VECTORS=256 -> fail_count equals count of nonzero golden results; first_fail_index=0.
//  5 abort asserted on 3rd busy cycle -> IDLE next edge, busy=0, done=0. Then start -> full run, counters cleared first.
//  6 start held high throughout RUN -> ignored. reset asserted mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/alu_bist_ctrl.sv
// Built-in self-test initiator for the ALU: issues LFSR-driven operand/opcode vectors,
// compares the ALU response against a golden model and records the first failure.
module alu_bist_ctrl #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE12345
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        test_mode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_alucont,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output logic [15:0] first_fail_index,
    output logic [31:0] first_fail_result,
    output logic [31:0] first_fail_expected
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] idx_q, idx_d;
    logic [2:0]  op_sel_q, op_sel_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alucont_q, alucont_d;
    logic [15:0] fail_count_q, fail_count_d;
    logic [15:0] ff_index_q, ff_index_d;
    logic [31:0] ff_result_q, ff_result_d;
    logic [31:0] ff_expected_q, ff_expected_d;

    logic [31:0] exp_result;
    logic        mismatch;
    logic [15:0] nxt_idx;
    logic [31:0] nxt_lfsr;
    logic [2:0]  nxt_op;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    function automatic logic [2:0] op_code(input logic [2:0] sel);
        case (sel)
            3'd0:    op_code = 3'b010;
            3'd1:    op_code = 3'b110;
            3'd2:    op_code = 3'b000;
            3'd3:    op_code = 3'b001;
            default: op_code = 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [31:0] diff;
        diff = a + ~b + 32'd1;
        case (op)
            3'b010:  golden = a + b;
            3'b110:  golden = diff;
            3'b000:  golden = a & b;
            3'b001:  golden = a | b;
            3'b111:  golden = {31'b0, diff[31]};
            default: golden = 32'h0;
        endcase
    endfunction

    always_comb begin
        exp_result = golden(alu_a_q, alu_b_q, alucont_q);
        mismatch   = (alu_result != exp_result) || (alu_zero != (exp_result == 32'h0));
        nxt_idx    = idx_q + 16'd1;
        nxt_lfsr   = lfsr_step(lfsr_q);
        nxt_op     = (op_sel_q == 3'd4) ? 3'd0 : op_sel_q + 3'd1;

        state_d       = state_q;
        lfsr_d        = lfsr_q;
        idx_d         = idx_q;
        op_sel_d      = op_sel_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alucont_d     = alucont_q;
        fail_count_d  = fail_count_q;
        ff_index_d    = ff_index_q;
        ff_result_d   = ff_result_q;
        ff_expected_d = ff_expected_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d       = RUN;
                        fail_count_d  = 16'h0;
                        ff_index_d    = 16'h0;
                        ff_result_d   = 32'h0;
                        ff_expected_d = 32'h0;
                        idx_d         = 16'h0;
                        op_sel_d      = 3'd0;
                        lfsr_d        = SEED_EFF;
                        alu_a_d       = SEED_EFF;
                        alu_b_d       = {SEED_EFF[15:0], SEED_EFF[31:16]};
                        alucont_d     = op_code(3'd0);
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
                        if (fail_count_q == 16'h0) begin
                            ff_index_d    = idx_q;
                            ff_result_d   = alu_result;
                            ff_expected_d = exp_result;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d     = nxt_idx;
                        lfsr_d    = nxt_lfsr;
                        op_sel_d  = nxt_op;
                        alu_a_d   = nxt_lfsr;
                        alu_b_d   = (nxt_idx[2:0] == 3'b110) ? nxt_lfsr
                                                             : {nxt_lfsr[15:0], nxt_lfsr[31:16]};
                        alucont_d = op_code(nxt_op);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED_EFF;
            idx_q         <= 16'h0;
            op_sel_q      <= 3'd0;
            alu_a_q       <= 32'h0;
            alu_b_q       <= 32'h0;
            alucont_q     <= 3'b010;
            fail_count_q  <= 16'h0;
            ff_index_q    <= 16'h0;
            ff_result_q   <= 32'h0;
            ff_expected_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            idx_q         <= idx_d;
            op_sel_q      <= op_sel_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alucont_q     <= alucont_d;
            fail_count_q  <= fail_count_d;
            ff_index_q    <= ff_index_d;
            ff_result_q   <= ff_result_d;
            ff_expected_q <= ff_expected_d;
        end
    end

    assign busy                = (state_q == RUN);
    assign test_mode           = busy;
    assign done                = (state_q == DONE);
    assign pass                = done && (fail_count_q == 16'h0);
    assign alu_a               = alu_a_q;
    assign alu_b               = alu_b_q;
    assign alu_alucont         = alucont_q;
    assign fail_count          = fail_count_q;
    assign first_fail_index    = ff_index_q;
    assign first_fail_result   = ff_result_q;
    assign first_fail_expected = ff_expected_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: an 8-vector instance with hand-computed vectors and
// fault-injectable ALU, plus a 256-vector instance with zero seed and a stuck zero flag.
module tb_alu_bist_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // small instance (SEED=1, 8 vectors)
    logic        start_s, abort_s, zero_s, tm_s, busy_s, done_s, pass_s;
    logic [31:0] res_s, a_s, b_s, ffr_s, ffe_s;
    logic [2:0]  op_s;
    logic [15:0] fc_s, ffi_s;
    logic        f_res0, f_zero1;

    // large instance (SEED=0 -> 1, 256 vectors, zero flag stuck at 1)
    logic        start_l, abort_l, zero_l, tm_l, busy_l, done_l, pass_l;
    logic [31:0] res_l, a_l, b_l, ffr_l, ffe_l;
    logic [2:0]  op_l;
    logic [15:0] fc_l, ffi_l;

    alu_bist_ctrl #(.NUM_VECTORS(8), .SEED(32'h00000001)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
        .alu_result(res_s), .alu_zero(zero_s), .test_mode(tm_s),
        .alu_a(a_s), .alu_b(b_s), .alu_alucont(op_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .fail_count(fc_s), .first_fail_index(ffi_s),
        .first_fail_result(ffr_s), .first_fail_expected(ffe_s));

    alu_bist_ctrl #(.NUM_VECTORS(256), .SEED(32'h00000000)) u_dut_l (
        .clk(clk), .reset(reset), .start(start_l), .abort(abort_l),
        .alu_result(res_l), .alu_zero(zero_l), .test_mode(tm_l),
        .alu_a(a_l), .alu_b(b_l), .alu_alucont(op_l), .busy(busy_l), .done(done_l),
        .pass(pass_l), .fail_count(fc_l), .first_fail_index(ffi_l),
        .first_fail_result(ffr_l), .first_fail_expected(ffe_l));

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] d;
        d = a - b;
        alu_ref = 32'h0;
        if (op == 3'b010) alu_ref = a + b;
        else if (op == 3'b110) alu_ref = d;
        else if (op == 3'b000) alu_ref = a & b;
        else if (op == 3'b001) alu_ref = a | b;
        else if (op == 3'b111) alu_ref = d[31] ? 32'd1 : 32'd0;
    endfunction

    logic [31:0] true_s;
    always_comb begin
        true_s = alu_ref(a_s, b_s, op_s);
        res_s  = f_res0 ? {true_s[31:1], 1'b0} : true_s;
        zero_s = f_zero1 ? 1'b1 : (true_s == 32'h0);
    end

    always_comb begin
        res_l  = alu_ref(a_l, b_l, op_l);
        zero_l = 1'b1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_s(input int max_cycles);
        for (int i = 0; i < max_cycles && !done_s; i++) tick();
        check("done_s_wait", {31'b0, done_s}, 32'd1);
    endtask

    // behavioural count of nonzero golden results for a 256-vector run from seed 1
    function automatic int count_nonzero_256();
        logic [31:0] lf, b, r;
        int cnt;
        lf = 32'h1;
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            b = ((k % 8) == 6) ? lf : {lf[15:0], lf[31:16]};
            case (k % 5)
                0: r = lf + b;
                1: r = lf - b;
                2: r = lf & b;
                3: r = lf | b;
                default: r = ($signed(lf - b) < 0) ? 32'd1 : 32'd0;
            endcase
            if (r != 32'h0) cnt++;
            lf = lf[0] ? ((lf >> 1) ^ 32'h80200003) : (lf >> 1);
        end
        return cnt;
    endfunction

    logic [31:0] exp_a  [8];
    logic [31:0] exp_b  [8];
    logic [2:0]  exp_op [8];
    int          nbusy;

    initial begin
        exp_a  = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001,
                   32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003};
        exp_b  = '{32'h00010000, 32'h00038020, 32'h0002C030, 32'h00016018,
                   32'h0003B02C, 32'h0002D836, 32'h6C1B0001, 32'h8003B62D};
        exp_op = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b110, 3'b000};

        reset = 1'b1; start_s = 1'b0; abort_s = 1'b0; start_l = 1'b0; abort_l = 1'b0;
        f_res0 = 1'b0; f_zero1 = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_busy",    {31'b0, busy_s}, 32'd0);
        check("rst_done",    {31'b0, done_s}, 32'd0);
        check("rst_pass",    {31'b0, pass_s}, 32'd0);
        check("rst_tm",      {31'b0, tm_s},   32'd0);
        check("rst_a",       a_s,             32'd0);
        check("rst_alucont", {29'b0, op_s},   32'd2);

        // fault-free 8-vector run; covers the sub-with-equal-operands zero at vector 6
        start_s = 1'b1; tick(); start_s = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("v%0d_a", k),  a_s,             exp_a[k]);
            check($sformatf("v%0d_b", k),  b_s,             exp_b[k]);
            check($sformatf("v%0d_op", k), {29'b0, op_s},   {29'b0, exp_op[k]});
            check($sformatf("v%0d_busy", k), {31'b0, busy_s}, 32'd1);
            tick();
        end
        check("run1_done", {31'b0, done_s}, 32'd1);
        check("run1_busy", {31'b0, busy_s}, 32'd0);
        check("run1_pass", {31'b0, pass_s}, 32'd1);
        check("run1_fc",   {16'b0, fc_s},   32'd0);
        check("run1_hold_a", a_s, 32'hB62D8003);

        // result bit 0 stuck at 0, restarted from DONE
        f_res0 = 1'b1;
        start_s = 1'b1; tick(); start_s = 1'b0;
        wait_done_s(20);
        check("sa0_fc",   {16'b0, fc_s},  32'd5);
        check("sa0_ffi",  {16'b0, ffi_s}, 32'd0);
        check("sa0_ffr",  ffr_s,          32'h00010000);
        check("sa0_ffe",  ffe_s,          32'h00010001);
        check("sa0_pass", {31'b0, pass_s}, 32'd0);
        f_res0 = 1'b0;

        // zero flag stuck at 1: every nonzero golden result fails
        f_zero1 = 1'b1;
        start_s = 1'b1; tick(); start_s = 1'b0;
        wait_done_s(20);
        check("sz1_fc",  {16'b0, fc_s},  32'd6);
        check("sz1_ffi", {16'b0, ffi_s}, 32'd0);
        check("sz1_ffr", ffr_s,          32'h00010001);
        f_zero1 = 1'b0;

        // abort on the third busy cycle with a result fault active
        f_res0 = 1'b1;
        start_s = 1'b1; tick(); start_s = 1'b0;
        check("ab_cleared", {16'b0, fc_s}, 32'd0);
        tick(); tick();
        check("ab_busy3", {31'b0, busy_s}, 32'd1);
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        check("ab_busy", {31'b0, busy_s}, 32'd0);
        check("ab_done", {31'b0, done_s}, 32'd0);
        check("ab_tm",   {31'b0, tm_s},   32'd0);
        tick(); tick();
        check("ab_fc",   {16'b0, fc_s},   32'd2);
        check("ab_hold_a", a_s,           32'hC0300002);
        f_res0 = 1'b0;

        // start held high through the run: busy exactly 8 cycles, counters cleared
        start_s = 1'b1; tick();
        check("hold_cleared", {16'b0, fc_s}, 32'd0);
        nbusy = 0;
        while (busy_s && nbusy < 20) begin
            nbusy++;
            tick();
        end
        start_s = 1'b0;
        check("hold_nbusy", nbusy,            32'd8);
        check("hold_done",  {31'b0, done_s},  32'd1);
        check("hold_pass",  {31'b0, pass_s},  32'd1);

        // reset in the middle of a run
        start_s = 1'b1; tick(); start_s = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mr_busy",    {31'b0, busy_s}, 32'd0);
        check("mr_done",    {31'b0, done_s}, 32'd0);
        check("mr_a",       a_s,             32'd0);
        check("mr_b",       b_s,             32'd0);
        check("mr_alucont", {29'b0, op_s},   32'd2);
        check("mr_fc",      {16'b0, fc_s},   32'd0);

        // 256-vector run, zero seed replaced by 1, zero flag stuck at 1
        start_l = 1'b1; tick(); start_l = 1'b0;
        check("big_a0", a_l, 32'h00000001);
        for (int i = 0; i < 300 && !done_l; i++) tick();
        check("big_done", {31'b0, done_l}, 32'd1);
        check("big_fc",   {16'b0, fc_l},   count_nonzero_256());
        check("big_ffi",  {16'b0, ffi_l},  32'd0);
        check("big_pass", {31'b0, pass_l}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
